// File: rtl/addsub_seq_if.sv
// Operand/result bundle for the slice-serial adder.
// Master issues operations, slave computes them.
interface addsub_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             half_carry;
  logic             overflow;
  logic             zero;

  modport master (
    output start, a, b, sub, carry_in,
    input  busy, done, res, carry,
    input  half_carry, overflow, zero
  );

  modport slave (
    input  start, a, b, sub, carry_in,
    output busy, done, res, carry,
    output half_carry, overflow, zero
  );
endinterface

// File: rtl/addsub_seq.sv
// Slice-serial add/subtract: SLICE bits per clock,
// LSB slice first, flags valid on the done pulse.
module addsub_seq #(
  parameter int WIDTH    = 16,
  parameter int SLICE    = 4,
  parameter int HC_SLICE = 0
) (
  input logic         clk,
  input logic         reset,
  addsub_seq_if.slave bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa, opb, res_q;
  logic             cy;
  logic             carry_q, hc_q, ov_q, z_q;

  logic             accept, last;
  logic [SLICE-1:0] sa, sb;
  logic [SLICE:0]   ssum;
  logic [WIDTH-1:0] res_nx;
  logic             ov_nx;

  assign accept = bus.start && (state != RUN);
  assign last   = (cnt == CW'(N - 1));

  // One slice of the ripple: current slice sum merged into the result.
  always_comb begin
    sa     = opa[int'(cnt)*SLICE +: SLICE];
    sb     = opb[int'(cnt)*SLICE +: SLICE];
    ssum   = {1'b0, sa} + {1'b0, sb} + {{SLICE{1'b0}}, cy};
    res_nx = res_q;
    res_nx[int'(cnt)*SLICE +: SLICE] = ssum[SLICE-1:0];
    // carry into the slice MSB recovered as sum ^ a ^ b
    ov_nx  = ssum[SLICE] ^ ssum[SLICE-1] ^ sa[SLICE-1] ^ sb[SLICE-1];
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Operand capture and per-slice accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      opa     <= '0;
      opb     <= '0;
      cy      <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      hc_q    <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b0;
    end else if (accept) begin
      opa <= bus.a;
      opb <= bus.sub ? ~bus.b : bus.b;
      cy  <= bus.carry_in;
      cnt <= '0;
    end else if (state == RUN) begin
      res_q <= res_nx;
      cy    <= ssum[SLICE];
      cnt   <= cnt + 1'b1;
      if (cnt == CW'(HC_SLICE)) hc_q <= ssum[SLICE];
      if (last) begin
        cnt     <= '0;
        carry_q <= ssum[SLICE];
        ov_q    <= ov_nx;
        z_q     <= (res_nx == '0);
      end
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.res        = res_q;
  assign bus.carry      = carry_q;
  assign bus.half_carry = hc_q;
  assign bus.overflow   = ov_q;
  assign bus.zero       = z_q;
endmodule
